f1_reaction_timer: RTL and testbench

- Receiving end of the F1 start-light sequencer: watches the 8-bit light bus and checks that it fills as a legal thermometer (00→01→03→…→FF→00).
- Times the driver's reaction from lights-out (FF→00) to the first button press, counting in timebase ticks.
- Flags jump starts (press before lights-out) and illegal light sequences.
- Sits alongside the light FSM; results go to the display/scoring logic.

---
 rtl/f1_reaction_timer.sv | 144 ++++++++++++++
 tb/tb_f1_reaction_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer
// Receiving end of the F1 start-light sequencer. Watches the light bus fill
// as a thermometer (00 -> 01 -> 03 -> ... -> FF), then times the driver's
// reaction from lights-out (FF -> 00) to the first button press in timebase
// ticks. Flags jump starts and illegal light sequences.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   lights_in  - [7:0] light pattern from the start-light FSM
//   tick       - one-cycle timebase strobe; the reaction counter advances on it
//   btn        - synchronised driver button (level)
//   clear      - one-cycle request to discard results and return to IDLE
//   time_out   - [TW-1:0] captured reaction time in ticks
//   time_valid - sticky: time_out holds a valid result
//   jump_start - sticky: press seen before lights-out
//   seq_error  - sticky: illegal light transition seen
//   busy       - high while a run is in progress (ARMED, FULL, TIMING)
module f1_reaction_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    lights_in,
  input  logic          tick,
  input  logic          btn,
  input  logic          clear,
  output logic [TW-1:0] time_out,
  output logic          time_valid,
  output logic          jump_start,
  output logic          seq_error,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FULL,
    TIMING,
    DONE,
    JUMP,
    ERROR
  } state_t;

  localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};

  state_t        state;
  logic [7:0]    lp;
  logic          bq;
  logic [TW-1:0] cnt;
  logic          press;
  logic          step_ok;

  // Rising edge of the button: holding it down yields a single press.
  assign press = btn & ~bq;

  // A legal step either holds the pattern or lights exactly one more lamp.
  assign step_ok = (lights_in == lp) || (lights_in == {lp[6:0], 1'b1});

  // Main sequencer. busy and the flags are updated alongside each state
  // change so every output is a plain register. The history registers lp
  // and bq track their inputs regardless of clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lp         <= 8'h00;
      bq         <= 1'b0;
      cnt        <= '0;
      time_out   <= '0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
      seq_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lp <= lights_in;
      bq <= btn;
      if (clear) begin
        state      <= IDLE;
        cnt        <= '0;
        time_valid <= 1'b0;
        jump_start <= 1'b0;
        seq_error  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (lp == 8'h00 && lights_in == 8'h01) begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
          ARMED: begin
            if (press) begin
              state      <= JUMP;
              jump_start <= 1'b1;
              busy       <= 1'b0;
            end else if (step_ok && lights_in == 8'hFF) begin
              state <= FULL;
            end else if (!step_ok) begin
              state     <= ERROR;
              seq_error <= 1'b1;
              busy      <= 1'b0;
            end
          end
          FULL: begin
            // A press on the very cycle the lights go out is still early.
            if (press) begin
              state      <= JUMP;
              jump_start <= 1'b1;
              busy       <= 1'b0;
            end else if (lights_in == 8'h00) begin
              state <= TIMING;
              cnt   <= '0;
            end else if (lights_in != 8'hFF) begin
              state     <= ERROR;
              seq_error <= 1'b1;
              busy      <= 1'b0;
            end
          end
          TIMING: begin
            // The press captures the count as it stands; a coincident tick
            // is not added.
            if (press) begin
              state      <= DONE;
              time_out   <= cnt;
              time_valid <= 1'b1;
              busy       <= 1'b0;
            end else if (tick && cnt != '1) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DONE, JUMP, ERROR: begin
            state <= state;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer
// Directed self-checking bench for f1_reaction_timer. Two instances share the
// same stimulus: the default TW=16 one and a TW=4 one used to observe counter
// saturation. Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same offset, so each check sees the result of the cycle
// just clocked.
module tb_f1_reaction_timer;

  logic        clk;
  logic        rst;
  logic [7:0]  lights_in;
  logic        tick;
  logic        btn;
  logic        clear;

  logic [15:0] time_out;
  logic        time_valid;
  logic        jump_start;
  logic        seq_error;
  logic        busy;

  logic [3:0]  s_time_out;
  logic        s_time_valid;
  logic        s_jump_start;
  logic        s_seq_error;
  logic        s_busy;

  int checks;
  int failures;

  f1_reaction_timer #(.TW(16)) dut (
    .clk(clk), .rst(rst), .lights_in(lights_in), .tick(tick), .btn(btn),
    .clear(clear), .time_out(time_out), .time_valid(time_valid),
    .jump_start(jump_start), .seq_error(seq_error), .busy(busy)
  );

  f1_reaction_timer #(.TW(4)) dut_small (
    .clk(clk), .rst(rst), .lights_in(lights_in), .tick(tick), .btn(btn),
    .clear(clear), .time_out(s_time_out), .time_valid(s_time_valid),
    .jump_start(s_jump_start), .seq_error(s_seq_error), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and advance past the next rising edge.
  task automatic applyStimulus(input logic [7:0] l, input logic t,
                               input logic b, input logic c);
    lights_in = l;
    tick      = t;
    btn       = b;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic holdLights(input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) applyStimulus(l, 1'b0, 1'b0, 1'b0);
  endtask

  // Walk the thermometer from 01 up to and including target, 4 cycles each.
  task automatic runTo(input logic [7:0] target);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 8; i++) begin
      holdLights(v, 4);
      if (v == target) break;
      v = {v[6:0], 1'b1};
    end
  endtask

  task automatic checkFlags(input string tag, input logic tv, input logic js,
                            input logic se, input logic bz);
    checkOutput({tag, ".time_valid"}, {31'd0, time_valid}, {31'd0, tv});
    checkOutput({tag, ".jump_start"}, {31'd0, jump_start}, {31'd0, js});
    checkOutput({tag, ".seq_error"},  {31'd0, seq_error},  {31'd0, se});
    checkOutput({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    lights_in = 8'h00;
    tick = 1'b0;
    btn  = 1'b0;
    clear = 1'b0;
    holdLights(8'h00, 2);
    rst = 1'b0;

    // Reset state
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.time_out", {16'd0, time_out}, 32'd0);

    // Nominal run: 5 ticks then a press gives 5
    holdLights(8'h00, 2);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("nom.busy_armed", {31'd0, busy}, 32'd1);
    holdLights(8'h01, 3);
    runTo(8'hFF);
    checkFlags("nom.full", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("nom.busy_timing", {31'd0, busy}, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkFlags("nom.done", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nom.time_out", {16'd0, time_out}, 32'd5);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("nom.sticky_time_out", {16'd0, time_out}, 32'd5);

    // Clear: flags drop, time_out retained
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkFlags("clr1", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr1.time_out", {16'd0, time_out}, 32'd5);

    // Jump start at 3F; later lights ignored
    runTo(8'h3F);
    applyStimulus(8'h3F, 1'b0, 1'b1, 1'b0);
    checkFlags("jump", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h3F, 1'b0, 1'b0, 1'b0);
    holdLights(8'h7F, 2);
    holdLights(8'hFF, 2);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    checkFlags("jump.sticky", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    // Press coincident with FF -> 00 is a jump start
    runTo(8'hFF);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkFlags("ffpress", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    // Press coincident with a tick at cnt=7 captures 7
    runTo(8'hFF);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("tickpress.time_out", {16'd0, time_out}, 32'd7);
    checkOutput("tickpress.valid", {31'd0, time_valid}, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    // Skipped light: 01, 03, 0F
    holdLights(8'h01, 2);
    holdLights(8'h03, 2);
    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
    checkFlags("skip", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    // FULL then FF -> 7F
    runTo(8'hFF);
    applyStimulus(8'h7F, 1'b0, 1'b0, 1'b0);
    checkFlags("fullback", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    // Saturation: 20 ticks; TW=4 saturates at 15, TW=16 counts 20
    runTo(8'hFF);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("sat.small_time_out", {28'd0, s_time_out}, 32'd15);
    checkOutput("sat.small_valid", {31'd0, s_time_valid}, 32'd1);
    checkOutput("sat.wide_time_out", {16'd0, time_out}, 32'd20);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("satclr.small_time_out", {28'd0, s_time_out}, 32'd15);
    checkOutput("satclr.small_flags",
                {29'd0, s_time_valid, s_jump_start, s_seq_error}, 32'd0);
    checkOutput("satclr.small_busy", {31'd0, s_busy}, 32'd0);

    // Reset mid-run abandons the sequence until a fresh 00 -> 01
    runTo(8'h1F);
    rst = 1'b1;
    applyStimulus(8'h1F, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    holdLights(8'h3F, 2);
    holdLights(8'h7F, 2);
    holdLights(8'hFF, 2);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkFlags("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.time_out", {16'd0, time_out}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.rearm_busy", {31'd0, busy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
